// File: rtl/puf_crp_sequencer.sv
// Challenge-response sequencer for the 8-stage arbiter PUF: an LFSR generates the
// challenges, each challenge is evaluated VOTES times, and every bit is majority-voted.
module puf_crp_sequencer #(
    parameter int C_LENGTH      = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int VOTES         = 5,
    parameter int NUM_CRP       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [C_LENGTH-1:0] seed,
    output logic                busy,
    output logic                done,
    output logic [C_LENGTH-1:0] puf_challenge,
    output logic                puf_pulse,
    input  logic [C_LENGTH-1:0] puf_response,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [C_LENGTH-1:0] out_data,
    output logic [C_LENGTH-1:0] out_challenge,
    output logic [C_LENGTH-1:0] out_unstable
);

    localparam int VW = $clog2(VOTES + 1);
    localparam int CW = (NUM_CRP > 1) ? $clog2(NUM_CRP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        SAMPLE,
        RELAX,
        OUTPUT
    } state_t;

    state_t        state;
    logic [7:0]    settle_cnt;
    logic [VW-1:0] eval_cnt;
    logic [CW-1:0] crp_cnt;
    logic [VW-1:0] vote_cnt [C_LENGTH];

    logic [C_LENGTH-1:0] lfsr_next;
    logic [C_LENGTH-1:0] voted;
    logic [C_LENGTH-1:0] unstable;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; taps only valid for an 8-bit challenge.
    assign lfsr_next = {puf_challenge[6:0],
                        puf_challenge[7] ^ puf_challenge[5] ^ puf_challenge[4] ^ puf_challenge[3]};

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        voted    = '0;
        unstable = '0;
        for (int i = 0; i < C_LENGTH; i++) begin
            voted[i]    = (vote_cnt[i] > VW'(VOTES / 2));
            unstable[i] = (vote_cnt[i] != '0) && (vote_cnt[i] != VW'(VOTES));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            eval_cnt      <= '0;
            crp_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            puf_challenge <= '0;
            puf_pulse     <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_challenge <= '0;
            out_unstable  <= '0;
            // NOTE: the vote counters are a small register array, not a RAM, so they are reset like any other state.
            for (int i = 0; i < C_LENGTH; i++) vote_cnt[i] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        puf_challenge <= (seed == '0) ? C_LENGTH'(1) : seed;
                        crp_cnt       <= '0;
                        eval_cnt      <= '0;
                        for (int i = 0; i < C_LENGTH; i++) vote_cnt[i] <= '0;
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end

                LOAD: begin
                    settle_cnt <= '0;
                    puf_pulse  <= 1'b1;
                    state      <= LAUNCH;
                end

                LAUNCH: begin
                    if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end

                SAMPLE: begin
                    for (int i = 0; i < C_LENGTH; i++)
                        vote_cnt[i] <= vote_cnt[i] + VW'(puf_response[i]);
                    eval_cnt  <= eval_cnt + VW'(1);
                    puf_pulse <= 1'b0;
                    state     <= RELAX;
                end

                RELAX: begin
                    if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
                        settle_cnt <= '0;
                        if (eval_cnt < VW'(VOTES)) begin
                            puf_pulse <= 1'b1;
                            state     <= LAUNCH;
                        end else begin
                            out_data      <= voted;
                            out_unstable  <= unstable;
                            out_challenge <= puf_challenge;
                            out_valid     <= 1'b1;
                            state         <= OUTPUT;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end

                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (crp_cnt == CW'(NUM_CRP - 1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            crp_cnt       <= crp_cnt + CW'(1);
                            puf_challenge <= lfsr_next;
                            eval_cnt      <= '0;
                            for (int i = 0; i < C_LENGTH; i++) vote_cnt[i] <= '0;
                            state         <= LOAD;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Directed bench for puf_crp_sequencer with a behavioural arbiter-PUF model:
// response = challenge ^ mask, optionally flipping bit 0 on alternate evaluations.
module tb_puf_crp_sequencer;

    localparam int NUM_CRP = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic       busy;
    logic       done;
    logic [7:0] puf_challenge;
    logic       puf_pulse;
    logic [7:0] puf_response;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_challenge;
    logic [7:0] out_unstable;

    puf_crp_sequencer #(
        .C_LENGTH(8), .SETTLE_CYCLES(4), .VOTES(5), .NUM_CRP(NUM_CRP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy), .done(done),
        .puf_challenge(puf_challenge), .puf_pulse(puf_pulse), .puf_response(puf_response),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_challenge(out_challenge), .out_unstable(out_unstable)
    );

    always #5 clk = ~clk;

    // PUF model
    logic [7:0] xor_mask;
    logic       flip_en;
    logic       flip_par;
    logic       eval_clr;
    logic       pulse_q;
    int         eval_idx;

    always @(posedge clk) begin
        pulse_q <= puf_pulse;
        if (eval_clr) eval_idx <= 0;
        else if (pulse_q && !puf_pulse) eval_idx <= eval_idx + 1;
    end

    always_comb begin
        puf_response = puf_challenge ^ xor_mask;
        if (flip_en && (eval_idx[0] == flip_par)) puf_response[0] = ~puf_response[0];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture of one run
    logic [7:0] got_ch [8];
    logic [7:0] got_dt [8];
    logic [7:0] got_un [8];
    int         got_t  [8];
    int         n_got;
    int         n_done;
    int         done_busy;

    // Assumes out_ready=1, so each valid cycle is exactly one transfer.
    task automatic collect(input int budget);
        int post;
        n_got = 0; n_done = 0; done_busy = 0; post = 0;
        for (int c = 0; c < budget; c++) begin
            if (out_valid && n_got < 8) begin
                got_ch[n_got] = out_challenge;
                got_dt[n_got] = out_data;
                got_un[n_got] = out_unstable;
                got_t[n_got]  = c;
                n_got++;
            end
            if (done) begin
                n_done++;
                if (busy) done_busy++;
            end
            if (n_done > 0) begin
                if (post >= 3) break;
                post++;
            end
            tick();
        end
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = -1;
        for (int c = 0; c < budget; c++) begin
            if (out_valid) begin
                cycles = c;
                break;
            end
            tick();
        end
        check("wait_valid_timeout", 32'(cycles >= 0), 32'd1);
    endtask

    task automatic pulse_start(input logic [7:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {busy, done, puf_pulse, out_valid, puf_challenge, out_data, out_challenge, out_unstable},
              32'h0);
    endtask

    logic [7:0] exp_ch_a [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    logic [7:0] exp_dt_a [5] = '{8'hA4, 8'hA7, 8'hA1, 8'hAD, 8'hB4};
    logic [7:0] exp_ch_b [5] = '{8'h55, 8'hAB, 8'h57, 8'hAF, 8'h5F};
    logic [7:0] exp_dt_b [5] = '{8'hF0, 8'h0E, 8'hF2, 8'h0A, 8'hFA};

    initial begin
        int lat, rises, perr, errs, cyc;
        logic prev, exp_p;

        rst_n = 1'b0; start = 1'b0; seed = 8'h00; out_ready = 1'b1;
        xor_mask = 8'hA5; flip_en = 1'b0; flip_par = 1'b0; eval_clr = 1'b1;
        tick(); tick();
        check_all_zero("reset_outputs");
        rst_n = 1'b1; eval_clr = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);

        // Seed 00, latency and launch-pulse shape, then the full run.
        pulse_start(8'h00);
        check("busy_after_start", busy, 1'b1);
        check("seed0_challenge", puf_challenge, 8'h01);
        lat = -1; rises = 0; perr = 0; prev = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k <= 45) begin
                exp_p = ((k - 1) % 9) < 5;
                if (puf_pulse !== exp_p) perr++;
                if (puf_pulse && !prev) rises++;
                prev = puf_pulse;
            end
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 46);
        check("pulse_pattern_err", perr, 0);
        check("pulse_windows", rises, 5);
        check("pulse_low_in_output", puf_pulse, 1'b0);
        collect(400);
        check("run_a_pairs", n_got, NUM_CRP);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("run_a_ch%0d", i), got_ch[i], exp_ch_a[i]);
            check($sformatf("run_a_dt%0d", i), got_dt[i], exp_dt_a[i]);
            check($sformatf("run_a_un%0d", i), got_un[i], 8'h00);
        end
        check("run_a_spacing", got_t[1] - got_t[0], 47);
        check("run_a_done_count", n_done, 1);
        check("run_a_done_busy", done_busy, 0);

        // Instability: bit 0 reads 1,0,1,0,1 then 0,1,0,1,0.
        for (int p = 0; p < 2; p++) begin
            xor_mask = 8'h00; flip_en = 1'b1; flip_par = p[0];
            eval_clr = 1'b1; tick(); eval_clr = 1'b0;
            pulse_start(8'h10);
            collect(400);
            check($sformatf("unstab%0d_ch", p), got_ch[0], 8'h10);
            check($sformatf("unstab%0d_dt", p), got_dt[0], (p == 0) ? 8'h11 : 8'h10);
            check($sformatf("unstab%0d_un", p), got_un[0], 8'h01);
            check($sformatf("unstab%0d_done", p), n_done, 1);
        end

        // Backpressure: 10 stalled cycles in OUTPUT.
        xor_mask = 8'hA5; flip_en = 1'b0; out_ready = 1'b0;
        tick();
        pulse_start(8'h20);
        wait_valid(100, cyc);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'h85 || out_challenge !== 8'h20 || puf_pulse !== 1'b0)
                errs++;
            tick();
        end
        check("stall_stable_err", errs, 0);
        out_ready = 1'b1;
        tick();
        check("xfer_valid_drop", out_valid, 1'b0);
        check("xfer_next_ch", puf_challenge, 8'h41);
        check("load_pulse_low", puf_pulse, 1'b0);
        tick();
        check("launch_after_load", puf_pulse, 1'b1);

        // Reset mid-LAUNCH of pair 3.
        wait_valid(100, cyc);
        tick();
        tick(); tick();
        check("pair3_launch", puf_pulse, 1'b1);
        rst_n = 1'b0;
        tick();
        check_all_zero("midrun_reset");
        rst_n = 1'b1;
        tick();
        pulse_start(8'h08);
        collect(400);
        check("post_reset_ch0", got_ch[0], 8'h08);
        check("post_reset_dt0", got_dt[0], 8'hAD);
        check("post_reset_ch1", got_ch[1], 8'h11);
        check("post_reset_pairs", n_got, NUM_CRP);

        // start held (and seed changed) while busy.
        seed = 8'h55; start = 1'b1;
        tick();
        seed = 8'hFF;
        for (int i = 0; i < 20; i++) tick();
        start = 1'b0;
        collect(400);
        check("busy_start_pairs", n_got, NUM_CRP);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("busy_start_ch%0d", i), got_ch[i], exp_ch_b[i]);
            check($sformatf("busy_start_dt%0d", i), got_dt[i], exp_dt_b[i]);
        end
        check("busy_start_done", n_done, 1);
        check("idle_after_run", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
